// File: rtl/display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// display_scan_ctrl
//
// Time-multiplexes four BCD digits onto one shared 7-segment decoder driving a
// common-anode display. Each digit slot is preceded by a blanking guard with
// all anodes off, which prevents ghosting. New digit values are
// double-buffered in a shadow register. They are committed to the active
// register only at a frame boundary, or when scanning starts, so the display
// never tears.
//
// Parameters:
//   SHOW_CYCLES   clk cycles one anode is lit per digit slot (>= 1)
//   BLANK_CYCLES  clk cycles all anodes are off before each digit slot (>= 1)
//
// Ports:
//   clk         in   1   system clock, all logic on posedge
//   reset       in   1   synchronous, active-high reset
//   enable      in   1   1 = scan, 0 = display dark (IDLE)
//   load        in   1   1-cycle strobe, captures digits_in into the shadow
//   digits_in   in   16  {d3,d2,d1,d0} BCD, d0 is the rightmost digit (an[0])
//   bcd         out  4   code to the decoder, 4'hF = blank
//   an          out  4   anode enables, active-low, one-hot-low or all ones
//   frame_tick  out  1   1-cycle pulse at each completed 4-digit frame
//
// Configuration macro:
//   LZB_EN  when defined, leading-zero blanking is applied to the active
//           digits: d3, d2 and d1 are blanked while they and all digits to
//           their left are zero. d0 is never blanked. A blanked slot still
//           strobes its anode, but with bcd = 4'hF.
// -----------------------------------------------------------------------------
module display_scan_ctrl #(
    parameter int unsigned SHOW_CYCLES  = 99000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        load,
    input  logic [15:0] digits_in,
    output logic [3:0]  bcd,
    output logic [3:0]  an,
    output logic        frame_tick
);

    localparam int unsigned DATA_W     = 16;
    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned IDX_W      = 2;
    localparam int unsigned MAX_CYCLES = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
    localparam int unsigned CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [CNT_W-1:0]   SHOW_LAST  = CNT_W'(SHOW_CYCLES - 1);
    localparam logic [CNT_W-1:0]   BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [DIGIT_W-1:0] BCD_BLANK  = 4'hF;
    localparam logic [3:0]         AN_OFF     = 4'b1111;
    localparam logic [IDX_W-1:0]   IDX_LAST   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } state_e;

    // Registered state
    state_e             state_q,   state_d;
    logic [IDX_W-1:0]   idx_q,     idx_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic [DATA_W-1:0]  active_q,  active_d;
    logic [DATA_W-1:0]  shadow_q,  shadow_d;
    logic               pending_q, pending_d;
    logic [3:0]         an_q,      an_d;
    logic [DIGIT_W-1:0] bcd_q,     bcd_d;
    logic               tick_q,    tick_d;

    // Combinational control strobes
    logic commit_c;
    logic enter_blank_c;

    // Code presented to the decoder for one slot, including optional LZB.
    function automatic logic [DIGIT_W-1:0] slot_code(
        input logic [DATA_W-1:0] digits,
        input logic [IDX_W-1:0]  idx
    );
        logic [DIGIT_W-1:0] dig;
        logic               blank;
        case (idx)
            2'd0:    dig = digits[3:0];
            2'd1:    dig = digits[7:4];
            2'd2:    dig = digits[11:8];
            default: dig = digits[15:12];
        endcase
`ifdef LZB_EN
        case (idx)
            2'd3:    blank = (digits[15:12] == 4'h0);
            2'd2:    blank = (digits[15:8]  == 8'h00);
            2'd1:    blank = (digits[15:4]  == 12'h000);
            default: blank = 1'b0;
        endcase
`else
        blank = 1'b0;
`endif
        return blank ? BCD_BLANK : dig;
    endfunction

    // Active-low anode pattern for the lit slot.
    function automatic logic [3:0] anode_mask(input logic [IDX_W-1:0] idx);
        logic [3:0] mask;
        case (idx)
            2'd0:    mask = 4'b1110;
            2'd1:    mask = 4'b1101;
            2'd2:    mask = 4'b1011;
            default: mask = 4'b0111;
        endcase
        return mask;
    endfunction

    // Next-state, datapath and output logic
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        cnt_d         = cnt_q;
        active_d      = active_q;
        shadow_d      = shadow_q;
        pending_d     = pending_q;
        an_d          = an_q;
        bcd_d         = bcd_q;
        tick_d        = 1'b0;
        commit_c      = 1'b0;
        enter_blank_c = 1'b0;

        // Shadow capture; the last load before a commit wins.
        if (load) begin
            shadow_d  = digits_in;
            pending_d = 1'b1;
        end

        if (!enable) begin
            // Dark display; shadow and pending are kept for the next start.
            state_d = ST_IDLE;
            idx_d   = '0;
            cnt_d   = '0;
            an_d    = AN_OFF;
            bcd_d   = BCD_BLANK;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d       = ST_BLANK;
                    idx_d         = '0;
                    cnt_d         = '0;
                    an_d          = AN_OFF;
                    commit_c      = 1'b1;
                    enter_blank_c = 1'b1;
                end
                ST_BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d = ST_SHOW;
                        cnt_d   = '0;
                        an_d    = anode_mask(idx_q);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_SHOW: begin
                    if (cnt_q == SHOW_LAST) begin
                        state_d       = ST_BLANK;
                        cnt_d         = '0;
                        an_d          = AN_OFF;
                        enter_blank_c = 1'b1;
                        if (idx_q == IDX_LAST) begin
                            idx_d    = '0;
                            tick_d   = 1'b1;
                            commit_c = 1'b1;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                    an_d    = AN_OFF;
                    bcd_d   = BCD_BLANK;
                end
            endcase
        end

        // Frame-boundary commit; a coincident load bypasses the shadow.
        if (commit_c) begin
            if (load) begin
                active_d  = digits_in;
                pending_d = 1'b0;
            end else if (pending_q) begin
                active_d  = shadow_q;
                pending_d = 1'b0;
            end
        end

        // bcd only changes on BLANK entry, using the just-committed digits.
        if (enter_blank_c) begin
            bcd_d = slot_code(active_d, idx_d);
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            active_q  <= '0;
            shadow_q  <= '0;
            pending_q <= 1'b0;
            an_q      <= AN_OFF;
            bcd_q     <= BCD_BLANK;
            tick_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            active_q  <= active_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            an_q      <= an_d;
            bcd_q     <= bcd_d;
            tick_q    <= tick_d;
        end
    end

    assign an         = an_q;
    assign bcd        = bcd_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_display_scan_ctrl
//
// Bench for display_scan_ctrl with SHOW_CYCLES=4 and BLANK_CYCLES=2, giving
// 6-cycle slots and 24-cycle frames. The driver applies inputs on the falling
// edge. It queues the outputs expected after the next rising edge. The
// monitor pops one entry per rising edge and compares it with the outputs.
// -----------------------------------------------------------------------------
module tb_display_scan_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        load;
    logic [15:0] digits_in;
    logic [3:0]  bcd;
    logic [3:0]  an;
    logic        frame_tick;

    typedef struct packed {
        logic [3:0] an;
        logic [3:0] bcd;
        logic       tick;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned n_cyc    = 0;

    localparam logic [15:0] IDLE_DIN = 16'hBEEF;
`ifdef LZB_EN
    localparam logic [15:0] CODES_0007 = 16'hFFF7;
`else
    localparam logic [15:0] CODES_0007 = 16'h0007;
`endif

    display_scan_ctrl #(
        .SHOW_CYCLES (4),
        .BLANK_CYCLES(2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .load      (load),
        .digits_in (digits_in),
        .bcd       (bcd),
        .an        (an),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    // One cycle of stimulus plus the outputs expected after the next edge.
    task automatic cyc(input logic rst, input logic en, input logic ld,
                       input logic [15:0] din, input logic [3:0] e_an,
                       input logic [3:0] e_bcd, input logic e_tick);
        exp_t e;
        @(negedge clk);
        reset     = rst;
        enable    = en;
        load      = ld;
        digits_in = din;
        e.an   = e_an;
        e.bcd  = e_bcd;
        e.tick = e_tick;
        sb.push_back(e);
    endtask

    // Up to one frame of enabled scanning. codes[4i+3:4i] is the bcd expected
    // in slot i. Up to two loads are issued at frame cycle offsets ld1_at and
    // ld2_at (-1 = none).
    task automatic frame(input logic [15:0] codes, input logic tick,
                         input int ld1_at, input logic [15:0] ld1_din,
                         input int ld2_at, input logic [15:0] ld2_din,
                         input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            int          i;
            int          k;
            logic        ld;
            logic [15:0] din;
            logic [3:0]  e_an;
            logic [3:0]  e_bcd;
            i     = c / 6;
            k     = c % 6;
            ld    = (c == ld1_at) || (c == ld2_at);
            din   = (c == ld2_at) ? ld2_din : ((c == ld1_at) ? ld1_din : IDLE_DIN);
            e_an  = (k < 2) ? 4'b1111 : ~(4'b0001 << i);
            e_bcd = 4'(codes >> (4 * i));
            cyc(1'b0, 1'b1, ld, din, e_an, e_bcd, tick && (c == 0));
        end
    endtask

    // Scoreboard monitor
    always @(posedge clk) begin
        #1;
        n_cyc++;
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            n_checks++;
            if ({an, bcd, frame_tick} === {mon_e.an, mon_e.bcd, mon_e.tick}) begin
                n_pass++;
            end else begin
                $display("FAIL outputs@cycle%0d: got an=%b bcd=%h tick=%b, want an=%b bcd=%h tick=%b",
                         n_cyc, an, bcd, frame_tick, mon_e.an, mon_e.bcd, mon_e.tick);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        enable    = 1'b0;
        load      = 1'b0;
        digits_in = 16'h0000;

        // Reset, then dark while disabled.
        cyc(1'b1, 1'b0, 1'b0, IDLE_DIN, 4'hF, 4'hF, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, IDLE_DIN, 4'hF, 4'hF, 1'b0);
        repeat (20) cyc(1'b0, 1'b0, 1'b0, IDLE_DIN, 4'hF, 4'hF, 1'b0);

        // Load 1234 while idle, then scan. The first frame has no tick.
        cyc(1'b0, 1'b0, 1'b1, 16'h1234, 4'hF, 4'hF, 1'b0);
        frame(16'h1234, 1'b0, -1, 16'h0, -1, 16'h0, 24);

        // Mid-frame load during slot 1 takes effect from the next frame.
        frame(16'h1234, 1'b1, 9, 16'h5678, -1, 16'h0, 24);
        frame(16'h5678, 1'b1, -1, 16'h0, -1, 16'h0, 24);

        // Disable during the SHOW phase of slot 2, then restart at slot 0.
        frame(16'h5678, 1'b1, -1, 16'h0, -1, 16'h0, 16);
        repeat (3) cyc(1'b0, 1'b0, 1'b0, IDLE_DIN, 4'hF, 4'hF, 1'b0);
        frame(16'h5678, 1'b0, -1, 16'h0, -1, 16'h0, 24);

        // A pending 4321 is overridden by a load coincident with the commit.
        frame(16'h5678, 1'b1, 8, 16'h4321, -1, 16'h0, 24);
        frame(16'h9012, 1'b1, 0, 16'h9012, -1, 16'h0, 24);

        // The last of two loads wins; non-BCD digits pass through.
        frame(16'h9012, 1'b1, 7, 16'h1111, 15, 16'hE0C0, 24);
        frame(16'hE0C0, 1'b1, 14, 16'h0007, -1, 16'h0, 24);

        // Leading zeros: blanked only when LZB_EN is defined.
        frame(CODES_0007, 1'b1, -1, 16'h0, -1, 16'h0, 24);

        // Reset mid-frame with enable held high clears the active digits.
        frame(CODES_0007, 1'b1, -1, 16'h0, -1, 16'h0, 9);
        cyc(1'b1, 1'b1, 1'b0, IDLE_DIN, 4'hF, 4'hF, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, IDLE_DIN, 4'hF, 4'hF, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, IDLE_DIN, 4'hF, 4'h0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, IDLE_DIN, 4'hF, 4'h0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, IDLE_DIN, 4'hE, 4'h0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, IDLE_DIN, 4'hF, 4'hF, 1'b0);

        // Every queued expectation must have been consumed.
        @(posedge clk);
        #2;
        n_checks++;
        if (sb.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
